// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types and defaults for the AES block sequencer
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    PROCESS = 3'd2,
    HOLD    = 3'd3,
    WRITE   = 3'd4,
    ERROR   = 3'd5
  } ctrl_state_t;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/aes_block_ctrl_timeout_counter.sv
// rtl/aes_block_ctrl_timeout_counter.sv - cycle counter with terminal-count flag at TIMEOUT-1
module timeout_counter #(
  parameter int TIMEOUT = aes_ctrl_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == W'(TIMEOUT - 1));

endmodule

// File: rtl/aes_block_ctrl.sv
// rtl/aes_block_ctrl.sv - one-block-in-flight sequencer between RX/TX FIFOs and the AES datapath
module aes_block_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             mode_sel,
  input  logic             key_ready,
  input  logic             rx_fifo_empty,
  input  logic             tx_fifo_full,
  input  logic             data_done,
  input  logic             data_valid,
  input  logic             clear_err,
  output logic             read_fifo,
  output logic             is_encrypt,
  output logic             tx_write,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] block_cnt
);

  ctrl_state_t      r_state;
  logic             r_read_fifo;
  logic             r_is_encrypt;
  logic             r_tx_write;
  logic             r_busy;
  logic             r_err;
  logic [CNT_W-1:0] r_block_cnt;

  logic w_start;
  logic w_timer_tc;

  assign w_start = enable & key_ready & ~rx_fifo_empty & ~tx_fifo_full;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (r_state == ISSUE),
    .i_enable (r_state == PROCESS),
    .o_tc     (w_timer_tc)
  );

  // Outputs are set on the edge entering a state so they are valid for that state's cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_read_fifo  <= 1'b0;
      r_is_encrypt <= 1'b1;
      r_tx_write   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_block_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state      <= ISSUE;
            r_is_encrypt <= mode_sel;
            r_read_fifo  <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ISSUE: begin
          r_read_fifo <= 1'b0;
          r_state     <= PROCESS;
        end
        PROCESS: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (data_done) begin
            if (!data_valid) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (tx_fifo_full) begin
              r_state <= HOLD;
            end else begin
              r_state    <= WRITE;
              r_tx_write <= 1'b1;
            end
          end else if (w_timer_tc) begin
            r_state <= ERROR;
            r_err   <= 1'b1;
          end
        end
        HOLD: begin
          if (!tx_fifo_full) begin
            r_state    <= WRITE;
            r_tx_write <= 1'b1;
          end
        end
        WRITE: begin
          r_tx_write  <= 1'b0;
          r_block_cnt <= r_block_cnt + 1'b1;
          r_state     <= IDLE;
          r_busy      <= 1'b0;
        end
        ERROR: begin
          if (clear_err) begin
            r_err   <= 1'b0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_read_fifo <= 1'b0;
          r_tx_write  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign read_fifo  = r_read_fifo;
  assign is_encrypt = r_is_encrypt;
  assign tx_write   = r_tx_write;
  assign busy       = r_busy;
  assign err        = r_err;
  assign block_cnt  = r_block_cnt;

endmodule

// File: tb/tb_aes_block_ctrl.sv
// tb/tb_aes_block_ctrl.sv - directed self-checking bench for aes_block_ctrl
module tb_aes_block_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;

  logic             clk;
  logic             n_rst;
  logic             enable;
  logic             mode_sel;
  logic             key_ready;
  logic             rx_fifo_empty;
  logic             tx_fifo_full;
  logic             data_done;
  logic             data_valid;
  logic             clear_err;
  logic             read_fifo;
  logic             is_encrypt;
  logic             tx_write;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] block_cnt;

  int errors = 0;
  int checks = 0;
  int tx_pulses = 0;
  int rd_pulses = 0;
  logic overlap_seen = 1'b0;

  aes_block_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .enable        (enable),
    .mode_sel      (mode_sel),
    .key_ready     (key_ready),
    .rx_fifo_empty (rx_fifo_empty),
    .tx_fifo_full  (tx_fifo_full),
    .data_done     (data_done),
    .data_valid    (data_valid),
    .clear_err     (clear_err),
    .read_fifo     (read_fifo),
    .is_encrypt    (is_encrypt),
    .tx_write      (tx_write),
    .busy          (busy),
    .err           (err),
    .block_cnt     (block_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_write === 1'b1) tx_pulses++;
    if (read_fifo === 1'b1) rd_pulses++;
    if (read_fifo === 1'b1 && tx_write === 1'b1) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one block; returns with the DUT in its first PROCESS cycle.
  task automatic issue(input logic m);
    mode_sel      = m;
    rx_fifo_empty = 1'b0;
    tick();
    rx_fifo_empty = 1'b1;
    tick();
  endtask

  task automatic full_block(input logic m);
    issue(m);
    data_done  = 1'b1;
    data_valid = 1'b1;
    tick();
    data_done  = 1'b0;
    data_valid = 1'b0;
    tick();
  endtask

  int tx0;
  int rd0;
  logic hold_wrote;

  initial begin
    n_rst = 1'b0; enable = 1'b0; mode_sel = 1'b0; key_ready = 1'b0;
    rx_fifo_empty = 1'b1; tx_fifo_full = 1'b0; data_done = 1'b0;
    data_valid = 1'b0; clear_err = 1'b0;
    tick(); tick();
    check("rst_read_fifo", read_fifo, 0);
    check("rst_tx_write", tx_write, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_block_cnt", block_cnt, 0);
    check("rst_is_encrypt", is_encrypt, 1);
    n_rst = 1'b1;
    tick();

    // Basic block: encrypt, done 10 cycles after read_fifo
    enable = 1'b1; key_ready = 1'b1; mode_sel = 1'b1; rx_fifo_empty = 1'b0;
    tick();
    check("t1_read_fifo_hi", read_fifo, 1);
    check("t1_busy", busy, 1);
    rx_fifo_empty = 1'b1;
    tick();
    check("t1_read_fifo_lo", read_fifo, 0);
    check("t1_is_encrypt", is_encrypt, 1);
    for (int i = 0; i < 9; i++) tick();
    data_done = 1'b1; data_valid = 1'b1;
    tick();
    check("t1_tx_write_hi", tx_write, 1);
    data_done = 1'b0; data_valid = 1'b0;
    tick();
    check("t1_tx_write_lo", tx_write, 0);
    check("t1_block_cnt", block_cnt, 1);
    check("t1_busy_lo", busy, 0);
    check("t1_rd_pulses", rd_pulses, 1);
    check("t1_tx_pulses", tx_pulses, 1);

    // Mode latched at issue only
    issue(1'b0);
    check("t2_is_encrypt_0", is_encrypt, 0);
    mode_sel = 1'b1;
    tick(); tick(); tick();
    check("t2_mid_process", is_encrypt, 0);
    data_done = 1'b1; data_valid = 1'b1;
    tick();
    check("t2_write_tx", tx_write, 1);
    check("t2_write_mode", is_encrypt, 0);
    data_done = 1'b0; data_valid = 1'b0;
    tick();
    full_block(1'b1);
    check("t2_next_mode", is_encrypt, 1);
    check("t2_block_cnt", block_cnt, 3);

    // TX backpressure: HOLD for 5 cycles
    issue(1'b1);
    tx_fifo_full = 1'b1; data_done = 1'b1; data_valid = 1'b1;
    tick();
    data_done = 1'b0; data_valid = 1'b0;
    tx0 = tx_pulses;
    hold_wrote = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (tx_write !== 1'b0 || busy !== 1'b1) hold_wrote = 1'b1;
      if (i < 4) tick();
    end
    check("t3_hold_quiet", hold_wrote, 0);
    tx_fifo_full = 1'b0;
    tick();
    check("t3_tx_after_release", tx_write, 1);
    tick();
    check("t3_tx_once", tx_pulses - tx0, 1);
    check("t3_block_cnt", block_cnt, 4);

    // Timeout into ERROR, then clear
    tx0 = tx_pulses;
    issue(1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t4_pre_timeout_err", err, 0);
    tick();
    check("t4_err", err, 1);
    check("t4_busy", busy, 1);
    tick(); tick();
    check("t4_err_sticky", err, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4_err_cleared", err, 0);
    check("t4_busy_cleared", busy, 0);
    check("t4_no_tx", tx_pulses - tx0, 0);

    // data_done on the timeout cycle wins
    issue(1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    data_done = 1'b1; data_valid = 1'b1;
    tick();
    data_done = 1'b0; data_valid = 1'b0;
    check("t4_edge_tx", tx_write, 1);
    check("t4_edge_err", err, 0);
    tick();
    check("t4_edge_cnt", block_cnt, 5);

    // Invalid completion: drop without write
    tx0 = tx_pulses;
    issue(1'b1);
    tick(); tick(); tick();
    data_done = 1'b1; data_valid = 1'b0;
    tick();
    data_done = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_tx_write", tx_write, 0);
    tick();
    check("t5_no_tx", tx_pulses - tx0, 0);
    check("t5_block_cnt", block_cnt, 5);

    // Counter wrap at 2^CNT_W
    for (int i = 0; i < 11; i++) full_block(1'b1);
    check("t6_wrap", block_cnt, 0);
    full_block(1'b1);
    check("t6_after_wrap", block_cnt, 1);

    // Asynchronous reset mid-PROCESS
    tx0 = tx_pulses;
    issue(1'b0);
    tick();
    check("t6_pre_rst_mode", is_encrypt, 0);
    data_done = 1'b1; data_valid = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cnt", block_cnt, 0);
    check("t6_rst_mode", is_encrypt, 1);
    check("t6_rst_tx", tx_write, 0);
    tick();
    data_done = 1'b0; data_valid = 1'b0;
    n_rst = 1'b1;
    tick(); tick(); tick();
    check("t6_no_tx_after", tx_pulses - tx0, 0);
    check("t6_idle_after", busy, 0);
    check("no_overlap", overlap_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_block_ctrl.md
Name: aes_block_ctrl

Overview:
Sequencer for the AES datapath block. It pulls one 128-bit block at a time from the RX FIFO into the AES datapath and latches the encrypt/decrypt mode per block. It waits for completion, applies TX FIFO backpressure before committing the write, and counts blocks. It sits between the top-level FIFOs/key-expansion logic and the AES datapath, and drives the datapath's read_fifo and is_encrypt inputs.

Parameters:
CNT_W, 16, width of the completed-block counter.
TIMEOUT, 64, cycles allowed in PROCESS before the error state is entered.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
enable  input  1  level; permits new blocks to be issued
mode_sel  input  1  requested mode (1 = encrypt, 0 = decrypt); sampled only at issue
key_ready  input  1  round keys expanded and stable
rx_fifo_empty  input  1  RX FIFO has no block
tx_fifo_full  input  1  TX FIFO cannot accept a block
data_done  input  1  datapath completion pulse
data_valid  input  1  datapath output qualifier, valid with data_done
clear_err  input  1  pulse; clears the sticky error
read_fifo  output  1  one-cycle pulse; RX pop and datapath start
is_encrypt  output  1  latched mode driven to the datapath
tx_write  output  1  one-cycle pulse; TX FIFO push
busy  output  1  high in any state except IDLE
err  output  1  sticky timeout error
block_cnt  output  CNT_W  count of blocks written to TX

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (n_rst).
- Reset values:
  - state IDLE; read_fifo 0, tx_write 0, busy 0, err 0, block_cnt 0, is_encrypt 1, timer 0.
  - Reset asserted mid-operation aborts immediately. No partial write occurs.
- All outputs are registered.
- States:
  - IDLE: if enable & key_ready & !rx_fifo_empty & !tx_fifo_full, go to ISSUE and latch is_encrypt <= mode_sel on that edge. Otherwise stay.
  - ISSUE: read_fifo = 1 for exactly this cycle. Clear timer. Go to PROCESS.
  - PROCESS: timer increments each cycle.
    - data_done & data_valid & !tx_fifo_full -> WRITE.
    - data_done & data_valid & tx_fifo_full -> HOLD.
    - data_done & !data_valid -> IDLE; no write, no count.
    - timer == TIMEOUT-1 with no data_done -> ERROR.
    - data_done in the same cycle as the timeout: data_done wins.
  - HOLD: wait; when !tx_fifo_full -> WRITE. HOLD has no timeout.
  - WRITE: tx_write = 1 for exactly this cycle. block_cnt <= block_cnt+1, wrapping modulo 2^CNT_W. Go to IDLE.
  - ERROR: err = 1, busy = 1. clear_err -> IDLE with err <= 0. clear_err in any other state is ignored.
- is_encrypt changes only on the IDLE->ISSUE edge. A mode_sel toggle mid-block has no effect on the current block.
- enable or key_ready deasserting after ISSUE does not abort; the current block completes. They are re-sampled in IDLE only.
- Key reload upstream must wait for busy = 0; the controller does not guard against it.
- Minimum issue period is 4 cycles (IDLE, ISSUE, PROCESS≥1, WRITE). No back-to-back issue without passing through IDLE.
- read_fifo and tx_write are never high in the same cycle.
- At most one block is in flight.

Decomposition:
- Package aes_ctrl_pkg holds:
  - state enum ctrl_state_t {IDLE, ISSUE, PROCESS, HOLD, WRITE, ERROR};
  - default TIMEOUT and CNT_W constants.
- One sub-module, timeout_counter: clear, enable, terminal-count flag at TIMEOUT-1.
- The FSM and block counter stay in aes_block_ctrl.

Test Plan:
1. Reset, then enable=1, key_ready=1, rx_fifo_empty=0, mode_sel=1; data_done & data_valid 10 cycles after read_fifo -> read_fifo one pulse, tx_write one pulse 1 cycle after data_done, is_encrypt=1, block_cnt=1, busy back to 0.
2. mode_sel=0 at issue, toggled to 1 mid-PROCESS -> is_encrypt stays 0 through WRITE; the next block latches 1.
3. tx_fifo_full=1 when data_done arrives, released 5 cycles later -> state HOLD, tx_write pulses exactly once, on the cycle after release.
4. No data_done for 64 cycles after ISSUE -> err=1, busy=1, no tx_write. clear_err pulse -> err=0, IDLE. Also data_done coinciding with cycle 63 -> WRITE, err stays 0.
5. data_done with data_valid=0 -> no tx_write, block_cnt unchanged, return to IDLE.
6. CNT_W=4; 16 blocks -> block_cnt wraps to 0. n_rst asserted mid-PROCESS -> all outputs at reset values asynchronously, no tx_write after release.
